// File: rtl/frame_scheduler_pkg.sv
// Shared types and defaults for the frame scheduler: FSM and slot encodings,
// default screen geometry and the engine-pointer width helper.
package frame_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_state_t;
    typedef enum logic [1:0] {FREE, BUSY, RESULT} slot_state_t;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_RGB_SIZE      = 24;
    localparam int DEFAULT_SCREEN_WIDTH  = 640;
    localparam int DEFAULT_SCREEN_HEIGHT = 480;
    localparam int DEFAULT_NUM_ENGINES   = 4;

    function automatic int ptr_width(input int num_engines);
        return (num_engines < 2) ? 1 : $clog2(num_engines);
    endfunction

endpackage

// File: rtl/frame_scheduler_raster_counter.sv
// Raster position counter: walks x first, then y, wrapping to (0,0) after the
// last pixel of the frame.
module raster_counter #(
    parameter int DATA_WIDTH    = 32,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  first,
    output logic                  last_x,
    output logic                  last_frame
);

    localparam logic [DATA_WIDTH-1:0] X_MAX = DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] Y_MAX = DATA_WIDTH'(SCREEN_HEIGHT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + DATA_WIDTH'(1);
            end else begin
                x <= x + DATA_WIDTH'(1);
            end
        end
    end

    assign first      = (x == '0) && (y == '0);
    assign last_x     = (x == X_MAX);
    assign last_frame = last_x && (y == Y_MAX);

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: dispatches raster coordinates round-robin to colour engines
// and re-serialises their results into an in-order pixel stream.
module frame_scheduler
    import frame_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int RGB_SIZE      = DEFAULT_RGB_SIZE,
    parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
    parameter int NUM_ENGINES   = DEFAULT_NUM_ENGINES
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            continuous,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            err_spurious,
    output logic [NUM_ENGINES-1:0]          eng_start,
    output logic [DATA_WIDTH-1:0]           eng_x,
    output logic [DATA_WIDTH-1:0]           eng_y,
    input  logic [NUM_ENGINES-1:0]          eng_done,
    input  logic [NUM_ENGINES*RGB_SIZE-1:0] eng_colour,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [RGB_SIZE-1:0]             out_colour,
    output logic                            out_first,
    output logic                            out_last_x,
    output logic                            out_last_y,
    output fsm_state_t                      dbg_state
);

    localparam int PW = ptr_width(NUM_ENGINES);

    fsm_state_t          state_q, state_d;
    slot_state_t         slot_q [NUM_ENGINES];
    logic [RGB_SIZE-1:0] cap_q  [NUM_ENGINES];
    logic [PW-1:0]       d_ptr_q, c_ptr_q;

    logic [DATA_WIDTH-1:0] d_x, d_y, o_x, o_y;
    logic d_first, d_last_x, d_last_frame;
    logic o_first, o_last_x, o_last_frame;
    logic dispatch_window, dispatch, handshake;
    logic unused_raster;

    raster_counter #(
        .DATA_WIDTH(DATA_WIDTH), .SCREEN_WIDTH(SCREEN_WIDTH), .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_dispatch_raster (
        .clk(clk), .reset(reset), .advance(dispatch),
        .x(d_x), .y(d_y), .first(d_first), .last_x(d_last_x), .last_frame(d_last_frame)
    );

    raster_counter #(
        .DATA_WIDTH(DATA_WIDTH), .SCREEN_WIDTH(SCREEN_WIDTH), .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_output_raster (
        .clk(clk), .reset(reset), .advance(handshake),
        .x(o_x), .y(o_y), .first(o_first), .last_x(o_last_x), .last_frame(o_last_frame)
    );

    assign unused_raster = ^{d_first, d_last_x, o_x, o_y};

    // Dispatch is decided on the edge that enters or stays in RUN, so the
    // registered eng_start is already visible in the first RUN cycle.
    always_comb begin
        state_d         = state_q;
        dispatch_window = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d         = RUN;
                    dispatch_window = 1'b1;
                end
            end
            RUN:   dispatch_window = 1'b1;
            DRAIN: if (handshake && o_last_frame) state_d = DONE;
            DONE: begin
                if (continuous) begin
                    state_d         = RUN;
                    dispatch_window = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        dispatch = dispatch_window && (slot_q[d_ptr_q] == FREE);
        if (dispatch && d_last_frame) state_d = DRAIN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Output stream handshake: a pixel transfers on any cycle where out_valid
    // and out_ready are both high; while out_valid is high and out_ready low,
    // out_colour and the flags hold because the head slot cannot change.
    assign out_valid  = (slot_q[c_ptr_q] == RESULT);
    assign handshake  = out_valid && out_ready;
    assign out_colour = out_valid ? cap_q[c_ptr_q] : '0;
    assign out_first  = out_valid && o_first;
    assign out_last_x = out_valid && o_last_x;
    assign out_last_y = out_valid && o_last_frame;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_ptr_q      <= '0;
            c_ptr_q      <= '0;
            eng_start    <= '0;
            eng_x        <= '0;
            eng_y        <= '0;
            err_spurious <= 1'b0;
            for (int i = 0; i < NUM_ENGINES; i++) begin
                slot_q[i] <= FREE;
                cap_q[i]  <= '0;
            end
        end else begin
            eng_start <= '0;
            eng_x     <= '0;
            eng_y     <= '0;
            if (dispatch) begin
                eng_start[d_ptr_q] <= 1'b1;
                eng_x              <= d_x;
                eng_y              <= d_y;
                d_ptr_q            <= d_last_frame ? '0 : d_ptr_q + PW'(1);
            end
            if (handshake) c_ptr_q <= o_last_frame ? '0 : c_ptr_q + PW'(1);
            // FREE->BUSY, BUSY->RESULT and RESULT->FREE need disjoint slot states,
            // so at most one of these updates applies to a slot in any cycle.
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (dispatch && (d_ptr_q == PW'(i))) slot_q[i] <= BUSY;
                if (eng_done[i]) begin
                    if (slot_q[i] == BUSY) begin
                        slot_q[i] <= RESULT;
                        cap_q[i]  <= eng_colour[i*RGB_SIZE +: RGB_SIZE];
                    end else begin
                        err_spurious <= 1'b1;
                    end
                end
                if (handshake && (c_ptr_q == PW'(i))) slot_q[i] <= FREE;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler on a 4x2 screen with four modelled colour engines;
// output and dispatch streams are checked against a raster-order reference.
module tb_frame_scheduler;

    localparam int DW   = 32;
    localparam int RGB  = 24;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int N    = 4;
    localparam int NPIX = W * H;
    localparam int OW   = 3 + RGB;
    localparam int DDW  = N + 2 * DW;

    logic clk, reset, start, continuous, out_ready;
    logic busy, frame_done, err_spurious, out_valid, out_first, out_last_x, out_last_y;
    logic [N-1:0] eng_start, eng_done, inject_mask;
    logic [DW-1:0] eng_x, eng_y;
    logic [N*RGB-1:0] eng_colour;
    logic [RGB-1:0] out_colour;
    logic [1:0] dbg_state;

    frame_scheduler #(
        .DATA_WIDTH(DW), .RGB_SIZE(RGB), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .NUM_ENGINES(N)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .busy(busy), .frame_done(frame_done), .err_spurious(err_spurious),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_colour(eng_colour),
        .out_valid(out_valid), .out_ready(out_ready), .out_colour(out_colour),
        .out_first(out_first), .out_last_x(out_last_x), .out_last_y(out_last_y),
        .dbg_state(dbg_state)
    );

    int checks = 0, failures = 0, cyc = 0;
    int done_cnt, start_pulses, outstanding, max_outstanding, busy_low, done_cyc;
    int hs_cyc[$];
    logic [OW-1:0]  exp_q[$], obs_out[$];
    logic [DDW-1:0] exp_d[$], obs_disp[$];
    int eng_lat[N];
    bit hold[N];
    bit rand_lat = 0, ready_rand = 0;
    int cnt[N];
    logic [DW-1:0] ex[N], ey[N];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc++;

    // ---------------- engine model ----------------
    initial begin
        eng_done = '0;
        eng_colour = '0;
        inject_mask = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            eng_done = inject_mask;
            inject_mask = '0;
            for (int i = 0; i < N; i++) begin
                if (cnt[i] > 1) cnt[i]--;
                else if (cnt[i] == 1 && !hold[i]) begin
                    eng_done[i] = 1'b1;
                    eng_colour[i*RGB +: RGB] = {8'h00, ey[i][7:0], ex[i][7:0]};
                    cnt[i] = 0;
                end
                if (eng_start[i]) begin
                    cnt[i] = rand_lat ? int'($urandom_range(1, 6)) : eng_lat[i];
                    ex[i] = eng_x;
                    ey[i] = eng_y;
                end
            end
        end
    end

    // ---------------- random downstream ready ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor (records only) ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                obs_out.push_back({out_first, out_last_x, out_last_y, out_colour});
                hs_cyc.push_back(cyc);
                outstanding--;
            end
            if (eng_start != '0) begin
                obs_disp.push_back({eng_start, eng_x, eng_y});
                start_pulses++;
                outstanding++;
                if (outstanding > max_outstanding) max_outstanding = outstanding;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!busy) busy_low++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [OW-1:0] model_pixel(input int k);
        logic [7:0] xb, yb;
        xb = 8'(k % W);
        yb = 8'(k / W);
        return {(k == 0), ((k % W) == W - 1), (k == NPIX - 1), 8'h00, yb, xb};
    endfunction

    function automatic logic [DDW-1:0] model_disp(input int k);
        logic [N-1:0] oh;
        oh = '0;
        oh[k % N] = 1'b1;
        return {oh, DW'(k % W), DW'(k / W)};
    endfunction

    task automatic build_expected(input int frames);
        exp_q.delete();
        exp_d.delete();
        for (int f = 0; f < frames; f++)
            for (int k = 0; k < NPIX; k++) begin
                exp_q.push_back(model_pixel(k));
                exp_d.push_back(model_disp(k));
            end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_obs();
        obs_out.delete(); obs_disp.delete(); hs_cyc.delete();
        done_cnt = 0; start_pulses = 0; outstanding = 0; max_outstanding = 0; busy_low = 0;
    endtask

    task automatic set_engines(input int lat);
        rand_lat = 0;
        for (int i = 0; i < N; i++) begin
            eng_lat[i] = lat;
            hold[i] = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int c = 0;
        while (done_cnt < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (done_cnt >= n);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; start = 1'b0; continuous = 1'b0; out_ready = 1'b0;
        set_engines(3);
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, frame_done, err_spurious, eng_start, eng_x, eng_y} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl actual=%b/%b/%b/%h/%h/%h required=all zero",
                     busy, frame_done, err_spurious, eng_start, eng_x, eng_y);
        end
        checks++;
        if ({out_valid, out_colour, out_first, out_last_x, out_last_y} !== '0) begin
            failures++;
            $display("FAIL reset_out actual=%b/%h/%b%b%b required=all zero",
                     out_valid, out_colour, out_first, out_last_x, out_last_y);
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || eng_start !== '0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b eng_start=%h required=0/0", busy, eng_start);
        end
    endtask

    task automatic test_basic_frame();
        bit ok;
        set_engines(3);
        out_ready = 1'b1;
        clear_obs();
        build_expected(1);
        pulse_start();
        wait_frames(1, 300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_timeout frame_done not seen"); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt != 1) begin
            failures++;
            $display("FAIL basic_end busy=%b done_cnt=%0d required=0/1", busy, done_cnt);
        end
        checks++;
        if (obs_out.size() != NPIX || obs_disp.size() != NPIX) begin
            failures++;
            $display("FAIL basic_count out=%0d disp=%0d required=%0d", obs_out.size(), obs_disp.size(), NPIX);
        end
        for (int k = 0; k < NPIX && k < obs_out.size(); k++) begin
            checks++;
            if (obs_out[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL basic_pixel%0d actual=%h required=%h", k, obs_out[k], exp_q[k]);
            end
        end
        for (int k = 0; k < NPIX && k < obs_disp.size(); k++) begin
            checks++;
            if (obs_disp[k] !== exp_d[k]) begin
                failures++;
                $display("FAIL basic_disp%0d actual=%h required=%h", k, obs_disp[k], exp_d[k]);
            end
        end
        if (hs_cyc.size() == NPIX) begin
            checks++;
            if (done_cyc != hs_cyc[NPIX-1] + 1) begin
                failures++;
                $display("FAIL basic_done_latency actual=%0d required=%0d", done_cyc, hs_cyc[NPIX-1] + 1);
            end
        end
        checks++;
        if (max_outstanding > N) begin
            failures++;
            $display("FAIL basic_outstanding actual=%0d required<=%0d", max_outstanding, N);
        end
    endtask

    task automatic test_out_of_order();
        bit ok;
        int vcount = 0;
        set_engines(1);
        hold[0] = 1'b1;
        hold[1] = 1'b1;
        out_ready = 1'b1;
        clear_obs();
        build_expected(1);
        pulse_start();
        repeat (12) @(negedge clk) if (out_valid) vcount++;
        checks++;
        if (vcount != 0 || start_pulses != N) begin
            failures++;
            $display("FAIL ooo_hold0 valid_cycles=%0d starts=%0d required=0/%0d", vcount, start_pulses, N);
        end
        @(posedge clk); #1 hold[1] = 1'b0;
        repeat (5) @(negedge clk) if (out_valid) vcount++;
        checks++;
        if (vcount != 0) begin
            failures++;
            $display("FAIL ooo_hold1 valid_cycles=%0d required=0", vcount);
        end
        @(posedge clk); #1 hold[0] = 1'b0;
        wait_frames(1, 300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ooo_timeout frame_done not seen"); end
        checks++;
        if (obs_out.size() != NPIX) begin
            failures++;
            $display("FAIL ooo_count actual=%0d required=%0d", obs_out.size(), NPIX);
        end
        for (int k = 0; k < NPIX && k < obs_out.size(); k++) begin
            checks++;
            if (obs_out[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL ooo_pixel%0d actual=%h required=%h", k, obs_out[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad = 0, sp0;
        set_engines(2);
        out_ready = 1'b0;
        clear_obs();
        build_expected(1);
        pulse_start();
        repeat (8) @(negedge clk);
        sp0 = start_pulses;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || {out_first, out_last_x, out_last_y, out_colour} !== model_pixel(0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_stable bad_cycles=%0d required=0", bad);
        end
        checks++;
        if (start_pulses != sp0 || sp0 != N) begin
            failures++;
            $display("FAIL bp_no_dispatch starts=%0d before=%0d required=%0d", start_pulses, sp0, N);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_frames(1, 300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_timeout frame_done not seen"); end
        if (hs_cyc.size() >= 4) begin
            checks++;
            if (hs_cyc[3] - hs_cyc[0] != 3) begin
                failures++;
                $display("FAIL bp_throughput span=%0d required=3", hs_cyc[3] - hs_cyc[0]);
            end
        end
        for (int k = 0; k < NPIX && k < obs_out.size(); k++) begin
            checks++;
            if (obs_out[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL bp_pixel%0d actual=%h required=%h", k, obs_out[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_continuous();
        bit ok1, ok2;
        int bl0;
        set_engines(1);
        rand_lat = 1;
        ready_rand = 1;
        continuous = 1'b1;
        clear_obs();
        build_expected(2);
        pulse_start();
        bl0 = busy_low;
        wait_frames(1, 600, ok1);
        @(posedge clk); #1 continuous = 1'b0;
        wait_frames(2, 600, ok2);
        checks++;
        if (!ok1 || !ok2) begin failures++; $display("FAIL cont_timeout frames=%0d required=2", done_cnt); end
        checks++;
        if (busy_low != bl0) begin
            failures++;
            $display("FAIL cont_busy_drop low_cycles=%0d required=0", busy_low - bl0);
        end
        ready_rand = 0;
        @(posedge clk); #2 out_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt != 2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_end done_cnt=%0d busy=%b required=2/0", done_cnt, busy);
        end
        checks++;
        if (obs_disp.size() > NPIX && obs_disp[NPIX][2*DW-1:0] !== '0) begin
            failures++;
            $display("FAIL cont_second_xy actual=%h required=0", obs_disp[NPIX][2*DW-1:0]);
        end
        checks++;
        if (obs_out.size() != 2 * NPIX) begin
            failures++;
            $display("FAIL cont_count actual=%0d required=%0d", obs_out.size(), 2 * NPIX);
        end
        for (int k = 0; k < 2 * NPIX && k < obs_out.size(); k++) begin
            checks++;
            if (obs_out[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL cont_pixel%0d actual=%h required=%h", k, obs_out[k], exp_q[k]);
            end
        end
        for (int k = 0; k < 2 * NPIX && k < obs_disp.size(); k++) begin
            checks++;
            if (obs_disp[k] !== exp_d[k]) begin
                failures++;
                $display("FAIL cont_disp%0d actual=%h required=%h", k, obs_disp[k], exp_d[k]);
            end
        end
        rand_lat = 0;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int c = 0;
        set_engines(3);
        eng_lat[1] = 20;
        out_ready = 1'b1;
        clear_obs();
        pulse_start();
        while (obs_out.size() < 5 && c < 300) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (obs_out.size() < 5) begin failures++; $display("FAIL mid_timeout pixels=%0d required=5", obs_out.size()); end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({busy, frame_done, err_spurious, eng_start, eng_x, eng_y, out_valid, out_colour,
             out_first, out_last_x, out_last_y} !== '0) begin
            failures++;
            $display("FAIL mid_async_zero busy=%b valid=%b start=%h colour=%h required=all zero",
                     busy, out_valid, eng_start, out_colour);
        end
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        c = 0;
        while (err_spurious !== 1'b1 && c < 60) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (err_spurious !== 1'b1) begin
            failures++;
            $display("FAIL mid_late_done err_spurious=%b required=1", err_spurious);
        end
        repeat (25) @(negedge clk);
        set_engines(3);
        clear_obs();
        build_expected(1);
        pulse_start();
        wait_frames(1, 300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_restart_timeout frame_done not seen"); end
        checks++;
        if (obs_disp.size() == 0 || obs_disp[0] !== model_disp(0)) begin
            failures++;
            $display("FAIL mid_first_dispatch actual=%h required=%h",
                     (obs_disp.size() > 0) ? obs_disp[0] : '0, model_disp(0));
        end
        for (int k = 0; k < NPIX && k < obs_out.size(); k++) begin
            checks++;
            if (obs_out[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL mid_pixel%0d actual=%h required=%h", k, obs_out[k], exp_q[k]);
            end
        end
        checks++;
        if (err_spurious !== 1'b1) begin
            failures++;
            $display("FAIL mid_err_sticky err_spurious=%b required=1", err_spurious);
        end
    endtask

    task automatic test_start_ignored_and_spurious();
        bit ok;
        apply_reset();
        #1;
        checks++;
        if (err_spurious !== 1'b0) begin
            failures++;
            $display("FAIL spur_cleared err_spurious=%b required=0", err_spurious);
        end
        set_engines(2);
        ready_rand = 1;
        clear_obs();
        build_expected(1);
        pulse_start();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_frames(1, 400, ok);
        ready_rand = 0;
        @(posedge clk); #2 out_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (!ok || done_cnt != 1 || busy !== 1'b0 || obs_out.size() != NPIX) begin
            failures++;
            $display("FAIL start_ignored done_cnt=%0d busy=%b pixels=%0d required=1/0/%0d",
                     done_cnt, busy, obs_out.size(), NPIX);
        end
        for (int k = 0; k < NPIX && k < obs_out.size(); k++) begin
            checks++;
            if (obs_out[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL si_pixel%0d actual=%h required=%h", k, obs_out[k], exp_q[k]);
            end
        end
        checks++;
        if (err_spurious !== 1'b0) begin
            failures++;
            $display("FAIL spur_none err_spurious=%b required=0", err_spurious);
        end
        @(posedge clk); #1 inject_mask = N'(2);
        repeat (2) @(negedge clk);
        checks++;
        if (err_spurious !== 1'b1) begin
            failures++;
            $display("FAIL spur_set err_spurious=%b required=1", err_spurious);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (err_spurious !== 1'b1) begin
            failures++;
            $display("FAIL spur_held err_spurious=%b required=1", err_spurious);
        end
        apply_reset();
        #1;
        checks++;
        if (err_spurious !== 1'b0) begin
            failures++;
            $display("FAIL spur_reset err_spurious=%b required=0", err_spurious);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_frame();
        test_out_of_order();
        test_backpressure();
        test_continuous();
        test_reset_midframe();
        test_start_ignored_and_spurious();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
